// File: rtl/fp_addsub_pipe_if.sv
// Stream interface for fp_addsub_pipe: operand/op request channel in, packed result and class out.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] result;
  logic [1:0]   state;

  // valid/ready: a beat transfers on the rising clk edge where vld and rdy are both high;
  // the producer holds vld and payload stable until that edge, and rdy may depend on the consumer side.
  modport master (output in_vld, a, b, op, out_rdy,
                  input  in_rdy, out_vld, result, state);
  modport slave  (input  in_vld, a, b, op, out_rdy,
                  output in_rdy, out_vld, result, state);
endinterface

// File: rtl/fp_addsub_pipe.sv
// Five-stage pipelined floating-point adder/subtractor, round-to-nearest-even, denormals flushed.
// S1 unpack/classify/swap, S2 align, S3 add/sub, S4 normalise, S5 round/pack into the output register.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = MAN_W + 4;
  localparam int LZ_W  = $clog2(EXT_W + 1);
  localparam int EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [EXP_W-1:0] E_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN   = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAN = 2'b01;
  localparam logic [1:0] ST_INF = 2'b10;
  localparam logic [1:0] ST_NUL = 2'b11;

  // Special-case outcome decided in S1 and carried beside the datapath.
  typedef struct packed {
    logic         hit;
    logic [W-1:0] word;
    logic [1:0]   st;
  } spec_t;

  logic         stall, adv;
  logic         out_vld_q;
  logic [W-1:0] result_q;
  logic [1:0]   state_q;
  logic         s1_vld, s2_vld, s3_vld, s4_vld;

  assign stall       = out_vld_q & ~bus.out_rdy;
  assign adv         = ~stall;
  assign bus.in_rdy  = adv;
  assign bus.out_vld = out_vld_q;
  assign bus.result  = result_q;
  assign bus.state   = state_q;

  // ---------------- S1: unpack, classify, swap ----------------
  logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  spec_t            sp_d;

  always_comb begin
    a_s    = bus.a[W-1];
    a_e    = bus.a[W-2:MAN_W];
    a_f    = bus.a[MAN_W-1:0];
    b_s    = bus.b[W-1] ^ bus.op;
    b_e    = bus.b[W-2:MAN_W];
    b_f    = bus.b[MAN_W-1:0];
    a_nan  = (a_e == E_ONES) && (a_f != '0);
    b_nan  = (b_e == E_ONES) && (b_f != '0);
    a_inf  = (a_e == E_ONES) && (a_f == '0);
    b_inf  = (b_e == E_ONES) && (b_f == '0);
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    swap   = bus.a[W-2:0] < bus.b[W-2:0];
    sp_d   = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      sp_d.hit = 1'b1; sp_d.word = QNAN; sp_d.st = ST_NAN;
    end else if (a_inf) begin
      sp_d.hit = 1'b1; sp_d.word = {a_s, bus.a[W-2:0]}; sp_d.st = ST_INF;
    end else if (b_inf) begin
      sp_d.hit = 1'b1; sp_d.word = {b_s, bus.b[W-2:0]}; sp_d.st = ST_INF;
    end else if (a_zero && b_zero) begin
      sp_d.hit = 1'b1; sp_d.word = {a_s & b_s, {(W-1){1'b0}}}; sp_d.st = ST_NUL;
    end else if (a_zero) begin
      sp_d.hit = 1'b1; sp_d.word = {b_s, bus.b[W-2:0]}; sp_d.st = ST_OK;
    end else if (b_zero) begin
      sp_d.hit = 1'b1; sp_d.word = {a_s, bus.a[W-2:0]}; sp_d.st = ST_OK;
    end
  end

  spec_t            s1_sp;
  logic             s1_sx, s1_sy;
  logic [EXP_W-1:0] s1_ex, s1_diff;
  logic [SIG_W-1:0] s1_mx, s1_my;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sp   <= sp_d;
      s1_sx   <= swap ? b_s : a_s;
      s1_sy   <= swap ? a_s : b_s;
      s1_ex   <= swap ? b_e : a_e;
      s1_mx   <= swap ? {~b_zero, b_f} : {~a_zero, a_f};
      s1_my   <= swap ? {~a_zero, a_f} : {~b_zero, b_f};
      s1_diff <= swap ? (b_e - a_e) : (a_e - b_e);
    end
  end

  // ---------------- S2: align Y with sticky collection ----------------
  logic [EXT_W-1:0] y_ext, y_sh, y_mask, y_al;

  always_comb begin
    y_ext  = {s1_my, 3'b000};
    y_sh   = '0;
    y_mask = '0;
    if (int'(s1_diff) >= MAN_W + 3) begin
      y_al = {{(EXT_W-1){1'b0}}, |s1_my};
    end else begin
      y_sh   = y_ext >> s1_diff;
      y_mask = ~({EXT_W{1'b1}} << s1_diff);
      y_al   = y_sh | {{(EXT_W-1){1'b0}}, |(y_ext & y_mask)};
    end
  end

  spec_t            s2_sp;
  logic             s2_sx, s2_sy;
  logic [EXP_W-1:0] s2_ex;
  logic [EXT_W-1:0] s2_x, s2_y;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sp <= s1_sp;
      s2_sx <= s1_sx;
      s2_sy <= s1_sy;
      s2_ex <= s1_ex;
      s2_x  <= {s1_mx, 3'b000};
      s2_y  <= y_al;
    end
  end

  // ---------------- S3: add or subtract magnitudes (X >= Y after swap) ----------------
  logic [EXT_W:0] sum_d;

  always_comb begin
    if (s2_sx ^ s2_sy) sum_d = {1'b0, s2_x} - {1'b0, s2_y};
    else               sum_d = {1'b0, s2_x} + {1'b0, s2_y};
  end

  spec_t            s3_sp;
  logic             s3_sign;
  logic [EXP_W-1:0] s3_ex;
  logic [EXT_W:0]   s3_sum;

  always_ff @(posedge clk) begin
    if (adv) begin
      s3_sp   <= s2_sp;
      s3_sign <= s2_sx;
      s3_ex   <= s2_ex;
      s3_sum  <= sum_d;
    end
  end

  // ---------------- S4: normalise ----------------
  logic [LZ_W-1:0]  lzc;
  logic             found, flush;
  logic [EXT_W-1:0] norm;
  logic [EW-1:0]    e_w;

  always_comb begin
    lzc   = LZ_W'(EXT_W);
    found = 1'b0;
    for (int i = EXT_W - 1; i >= 0; i--) begin
      if (!found && s3_sum[i]) begin
        lzc   = LZ_W'(EXT_W - 1 - i);
        found = 1'b1;
      end
    end
    if (s3_sum[EXT_W]) begin
      norm = {s3_sum[EXT_W:2], |s3_sum[1:0]};
      e_w  = EW'(s3_ex) + EW'(1);
    end else begin
      norm = s3_sum[EXT_W-1:0] << lzc;
      e_w  = EW'(s3_ex) - EW'(lzc);
    end
    // A clear top bit after normalising means the sum was exactly zero.
    flush = ~s3_sum[EXT_W] & (~norm[EXT_W-1] | e_w[EW-1] | (e_w == '0));
  end

  spec_t            s4_sp;
  logic             s4_sign, s4_zero;
  logic [EXP_W-1:0] s4_e;
  logic [EXT_W-2:0] s4_m;

  always_ff @(posedge clk) begin
    if (adv) begin
      s4_sp   <= s3_sp;
      s4_sign <= s3_sign & norm[EXT_W-1];
      s4_zero <= flush;
      s4_e    <= e_w[EXP_W-1:0];
      s4_m    <= norm[EXT_W-2:0];
    end
  end

  // ---------------- S5: round to nearest even, pack ----------------
  logic [MAN_W-1:0] frac;
  logic             inc;
  logic [MAN_W:0]   frac_inc;
  logic [EXP_W:0]   e_rnd;
  logic [W-1:0]     res_d;
  logic [1:0]       st_d;

  always_comb begin
    frac     = s4_m[EXT_W-2:3];
    inc      = s4_m[2] & (s4_m[1] | s4_m[0] | frac[0]);
    frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    e_rnd    = {1'b0, s4_e} + {{EXP_W{1'b0}}, frac_inc[MAN_W]};
    res_d    = {s4_sign, e_rnd[EXP_W-1:0], frac_inc[MAN_W-1:0]};
    st_d     = ST_OK;
    if (s4_sp.hit) begin
      res_d = s4_sp.word;
      st_d  = s4_sp.st;
    end else if (s4_zero) begin
      res_d = {s4_sign, {(W-1){1'b0}}};
      st_d  = ST_NUL;
    end else if (e_rnd >= {1'b0, E_ONES}) begin
      res_d = {s4_sign, E_ONES, {MAN_W{1'b0}}};
      st_d  = ST_INF;
    end
  end

  // Valid chain and output register; only these carry reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s3_vld    <= 1'b0;
      s4_vld    <= 1'b0;
      out_vld_q <= 1'b0;
      result_q  <= '0;
      state_q   <= ST_OK;
    end else if (adv) begin
      s1_vld    <= bus.in_vld;
      s2_vld    <= s1_vld;
      s3_vld    <= s2_vld;
      s4_vld    <= s3_vld;
      out_vld_q <= s4_vld;
      if (s4_vld) begin
        result_q <= res_d;
        state_q  <= st_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed scoreboard bench for fp_addsub_pipe at single (8/23) and half (5/10) precision.
module tb_fp_addsub_pipe;
  localparam logic [1:0] OK = 2'b00, NAN = 2'b01, INF = 2'b10, NUL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) if32 ();
  fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) if16 ();

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  logic [33:0] exp_q32[$];
  logic [17:0] exp_q16[$];
  int          pop_cyc32[$];
  logic [33:0] mon_e32;
  logic [17:0] mon_e16;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst && if32.out_vld && if32.out_rdy) begin
      checks++;
      pop_cyc32.push_back(cyc);
      if (exp_q32.size() == 0) begin
        errors++;
        $display("FAIL res32 unexpected output got %h st %b", if32.result, if32.state);
      end else begin
        mon_e32 = exp_q32.pop_front();
        if ({if32.state, if32.result} !== mon_e32) begin
          errors++;
          $display("FAIL res32 got %h st %b exp %h st %b",
                   if32.result, if32.state, mon_e32[31:0], mon_e32[33:32]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if16.out_vld && if16.out_rdy) begin
      checks++;
      if (exp_q16.size() == 0) begin
        errors++;
        $display("FAIL res16 unexpected output got %h st %b", if16.result, if16.state);
      end else begin
        mon_e16 = exp_q16.pop_front();
        if ({if16.state, if16.result} !== mon_e16) begin
          errors++;
          $display("FAIL res16 got %h st %b exp %h st %b",
                   if16.result, if16.state, mon_e16[15:0], mon_e16[17:16]);
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1, return at posedge+1) ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic issue32(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                         input logic [31:0] res, input logic [1:0] st);
    bit done = 1'b0;
    if32.a = va; if32.b = vb; if32.op = vop; if32.in_vld = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (if32.in_rdy) begin
        exp_q32.push_back({st, res});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if32.in_vld = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue32 timeout in_rdy got 0 exp 1");
    end
  endtask

  task automatic issue16(input logic [15:0] va, input logic [15:0] vb, input logic vop,
                         input logic [15:0] res, input logic [1:0] st);
    bit done = 1'b0;
    if16.a = va; if16.b = vb; if16.op = vop; if16.in_vld = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (if16.in_rdy) begin
        exp_q16.push_back({st, res});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if16.in_vld = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue16 timeout in_rdy got 0 exp 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q32.size() != 0 || exp_q16.size() != 0) && n < 400) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain timeout pending32 %0d pending16 %0d exp 0", exp_q32.size(), exp_q16.size());
    end
  endtask

  // Backpressure / throughput table: small integers with distinct results.
  logic [31:0] bp_a [0:7] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h40800000,
                              32'h40800000, 32'h40800000, 32'h41000000, 32'h41000000};
  logic [31:0] bp_b [0:7] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000,
                              32'h40400000, 32'h40800000, 32'h3F800000, 32'h40C00000};
  logic        bp_op[0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] bp_r [0:7] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000,
                              32'h40E00000, 32'h41000000, 32'h41100000, 32'h40000000};

  // ---------------- main sequence ----------------
  initial begin
    int n, t0, stale;
    rst = 1'b1;
    if32.in_vld = 1'b0; if32.a = '0; if32.b = '0; if32.op = 1'b0; if32.out_rdy = 1'b1;
    if16.in_vld = 1'b0; if16.a = '0; if16.b = '0; if16.op = 1'b0; if16.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_vld", 64'(if32.out_vld), 64'd0);
    chk("rst_result",  64'(if32.result),  64'd0);
    chk("rst_state",   64'(if32.state),   64'd0);
    chk("rst_in_rdy",  64'(if32.in_rdy),  64'd1);
    @(posedge clk); #1;

    // Basic add with latency measurement, then subtract.
    issue32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, OK);
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (if32.out_vld) break;
    end
    chk("latency", 64'(n), 64'd5);
    @(posedge clk); #1;
    drain();
    issue32(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, OK);

    // Rounding, cancellation, carry and wide-shift cases.
    issue32(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, OK);
    issue32(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, OK);
    issue32(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, NUL);
    issue32(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, OK);
    issue32(32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, OK);
    issue32(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, OK);
    issue32(32'h40000000, 32'h3FC00000, 1'b1, 32'h3F000000, OK);

    // Specials.
    issue32(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, NAN);
    issue32(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, NAN);
    issue32(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, NAN);
    issue32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, INF);
    issue32(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, INF);
    issue32(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, INF);
    issue32(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, INF);
    issue32(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, OK);
    issue32(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, NUL);
    issue32(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, NUL);
    issue32(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, NUL);

    // Denormal flush.
    issue32(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, OK);
    issue32(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, NUL);
    drain();

    // Backpressure: 8 back-to-back issues against a stalled output.
    if32.out_rdy = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) issue32(bp_a[k], bp_b[k], bp_op[k], bp_r[k], OK);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_in_rdy",   64'(if32.in_rdy),  64'd0);
        chk("bp_out_vld",  64'(if32.out_vld), 64'd1);
        chk("bp_hold_a",   64'(if32.result),  64'h40400000);
        repeat (3) @(negedge clk);
        chk("bp_hold_b",   64'(if32.result),  64'h40400000);
        @(posedge clk); #1;
        if32.out_rdy = 1'b1;
      end
    join
    drain();

    // Throughput: 6 issues in 6 cycles and 6 results on consecutive cycles.
    pop_cyc32.delete();
    t0 = cyc;
    for (int k = 0; k < 6; k++) issue32(bp_a[k], bp_b[k], bp_op[k], bp_r[k], OK);
    chk("thru_issue", 64'(cyc - t0), 64'd6);
    drain();
    chk("thru_count", 64'(pop_cyc32.size()), 64'd6);
    if (pop_cyc32.size() == 6) chk("thru_span", 64'(pop_cyc32[5] - pop_cyc32[0]), 64'd5);

    // Reset with 3 transactions in flight.
    for (int k = 0; k < 3; k++) issue32(bp_a[k], bp_b[k], bp_op[k], bp_r[k], OK);
    rst = 1'b1;
    exp_q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_vld", 64'(if32.out_vld), 64'd0);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (if32.out_vld) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;
    issue32(32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, OK);
    drain();

    // Half precision generic.
    issue16(16'h3C00, 16'h4000, 1'b0, 16'h4200, OK);
    issue16(16'h3C00, 16'h4000, 1'b1, 16'hBC00, OK);
    issue16(16'h3C00, 16'h1000, 1'b0, 16'h3C00, OK);
    issue16(16'h3C00, 16'h1001, 1'b0, 16'h3C01, OK);
    issue16(16'h3C00, 16'h3C00, 1'b1, 16'h0000, NUL);
    issue16(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, NAN);
    issue16(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, NAN);
    issue16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, INF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
